client_my_fec_rx: RTL and testbench
===================================

Name: client_my_fec_rx

Overview:
- Receive-side counterpart of the column-FEC packet generator.
- Parses Ethernet/IP/UDP/RTP/FEC frames from the Ethernet core's receiver client interface and validates every header field.
- Writes the 1316-byte XOR payload into a ping-pong buffer and commits it, together with the extracted FEC header fields, only on a good, fully-matching frame.
- Feeds the downstream FEC recovery logic.

Parameters:
- PAYLOAD_OFFSET, 70: header length in bytes; payload starts at this byte index.
- FRAME_LEN, 1386: exact required frame length in bytes (70 + 7×188).
- PORT_FEC, 16'd8198: required UDP destination port.
- DST_MAC, 48'h01005e7f0001: required MAC destination.
- DST_IP, 32'hEFFF0001: required destination IP (239.255.0.1).
- RTP_PT, 7'd96: required RTP payload type.

Ports:
- rx_clk  in  1  receive clock; sole clock.
- reset_n  in  1  asynchronous, active-low reset.
- rx_data  in  8  frame byte from the Ethernet core.
- rx_data_valid  in  1  high for each valid byte; contiguous across a frame.
- rx_good_frame  in  1  one-cycle pulse after the last byte: FCS good.
- rx_bad_frame  in  1  one-cycle pulse after the last byte: FCS/frame error.
- pl_data  out  8  payload byte to the buffer.
- pl_addr  out  12  {bank, offset[10:0]}; offset 0..1315.
- pl_we  out  1  payload write enable.
- rd_bank  out  1  committed bank, readable downstream (= ~write bank).
- fec_valid  out  1  one-cycle pulse: new FEC packet committed.
- rtp_seq  out  16  RTP sequence number (bytes 44-45) of the committed packet.
- sn_base  out  16  FEC SNBase (bytes 54-55).
- fec_offset  out  8  byte 67.
- fec_na  out  8  byte 68.
- seq_gap  out  1  pulse with fec_valid when rtp_seq != previous + 1.
- drop_cnt  out  16  count of rejected frames; saturates at FFFF.

Behaviour:
- Reset values (reset_n low, asynchronous):
  - All outputs 0; write bank 0, so rd_bank = 1.
  - State IDLE; byte counter 0; header shadow registers 0; "first packet" flag set.
- States: IDLE, HDR, PAYLOAD, WAIT_STATUS, DROP.
- IDLE:
  - First rx_data_valid byte is byte 0. Go to HDR with counter = 1.
  - rx_good_frame or rx_bad_frame seen while in IDLE is ignored.
- HDR (bytes 0..69):
  - Compare each byte against its expected value: DST_MAC (0-5), 08 00 (12-13), 45 (14), 17 (23), DST_IP (30-33), PORT_FEC (36-37), byte42[7:6]=2, byte43[6:0]=RTP_PT, byte58[7]=1.
  - Any mismatch sets a sticky err flag; capture continues so the length check still runs.
  - Latch bytes 44-45, 54-55, 67, 68 into shadow registers.
  - IP checksum: 20-bit accumulator of the 16-bit words over bytes 14..33, including the received checksum; fold carries twice; result must equal FFFF, else err.
  - At byte 69 go to PAYLOAD.
- PAYLOAD:
  - Each valid byte drives pl_we=1, pl_data=rx_data, pl_addr={wr_bank, counter-70}, registered for 1 cycle of latency.
  - A byte at counter ≥ FRAME_LEN sets err and suppresses pl_we; no write beyond offset 1315.
- End of frame:
  - rx_data_valid falling ends the frame; go to WAIT_STATUS.
  - Length err if counter != FRAME_LEN.
- WAIT_STATUS:
  - rx_good_frame with err=0 commits:
    - toggle wr_bank; rd_bank follows;
    - copy shadows to rtp_seq, sn_base, fec_offset, fec_na;
    - pulse fec_valid for 1 cycle, the cycle after rx_good_frame;
    - seq_gap = ~first & (shadow_seq != rtp_seq_prev + 1) using 16-bit wrap, so FFFF→0000 is not a gap;
    - clear first.
  - rx_bad_frame, or rx_good_frame with err=1: drop_cnt++ (saturating); bank is not toggled; committed outputs unchanged. Go to IDLE.
  - If rx_data_valid rises again before any status pulse: count as a drop and start the new frame at byte 0.
- DROP: not entered from parse errors (they are sticky instead); entered only if the core asserts rx_bad_frame mid-frame. Consume bytes until rx_data_valid falls, then go to IDLE.
- Simultaneous rx_good_frame and rx_bad_frame: treated as bad.
- Reset mid-frame: state returns to IDLE immediately. The next frame must begin with rx_data_valid rising after reset_n deasserts; the remainder of the interrupted frame is parsed as a new frame and will fail the checks.
- Committed fields change only on a commit, and the committed bank is never written.

Test Plan:
- Valid frame: FRAME_LEN bytes, seq 0x0010, SNBase 0x1234, NA 04, then rx_good_frame → 1316 pl_we writes at {0, 0..1315}; fec_valid 1 cycle; rd_bank=0; sn_base=1234; seq_gap=0; drop_cnt=0.
- Two frames with seq 0x0010 then 0x0012 → second commit: rd_bank=1, seq_gap=1. Then seq FFFF followed by 0000 → seq_gap=0.
- UDP port 8196 (otherwise valid) with rx_good_frame → no fec_valid; drop_cnt=1; rd_bank unchanged.
- Corrupt IP checksum byte 25 → drop, drop_cnt+1. Valid frame followed by rx_bad_frame → drop, bank not toggled.
- Length cases: 1385-byte frame → drop. 1390-byte frame → drop, and no pl_we with offset > 1315.
- reset_n low at byte 500 of a frame → all outputs 0, rd_bank=1 asynchronously; next valid frame commits normally with seq_gap=0.

Source files
------------

// File: rtl/client_my_fec_rx.sv
// client_my_fec_rx
//   Receive side of the column-FEC path. Parses Ethernet/IPv4/UDP/RTP/FEC
//   frames from the MAC receive client, validates every fixed header field
//   plus the IPv4 header checksum, streams the XOR payload into one half of
//   a ping-pong buffer and commits that half together with the FEC header
//   fields only when the frame is good and fully matching.
// Ports
//   rx_clk, reset_n           clock, async active-low reset
//   rx_data/rx_data_valid     byte stream from the MAC (contiguous per frame)
//   rx_good_frame/bad_frame   status pulse after the last byte
//   pl_data/pl_addr/pl_we     payload buffer write port {bank, offset}
//   rd_bank                   committed bank (always ~write bank)
//   fec_valid/seq_gap         commit pulse and RTP sequence discontinuity
//   rtp_seq/sn_base/fec_offset/fec_na  committed header fields
//   drop_cnt                  saturating count of rejected frames
module client_my_fec_rx #(
  parameter int unsigned PAYLOAD_OFFSET = 70,
  parameter int unsigned FRAME_LEN      = 1386,
  parameter logic [15:0] PORT_FEC       = 16'd8198,
  parameter logic [47:0] DST_MAC        = 48'h01005e7f0001,
  parameter logic [31:0] DST_IP         = 32'hEFFF0001,
  parameter logic [6:0]  RTP_PT         = 7'd96
) (
  input  logic        rx_clk,
  input  logic        reset_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_data_valid,
  input  logic        rx_good_frame,
  input  logic        rx_bad_frame,
  output logic [7:0]  pl_data,
  output logic [11:0] pl_addr,
  output logic        pl_we,
  output logic        rd_bank,
  output logic        fec_valid,
  output logic [15:0] rtp_seq,
  output logic [15:0] sn_base,
  output logic [7:0]  fec_offset,
  output logic [7:0]  fec_na,
  output logic        seq_gap,
  output logic [15:0] drop_cnt
);

  localparam logic [11:0] HDR_LAST = 12'(PAYLOAD_OFFSET - 1);
  localparam logic [11:0] PL_OFF   = 12'(PAYLOAD_OFFSET);
  localparam logic [11:0] LEN      = 12'(FRAME_LEN);

  typedef enum logic [2:0] {IDLE, HDR, PAYLOAD, WAIT_STATUS, DROP} state_t;

  state_t      state_q, state_d;
  logic [11:0] cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [19:0] csum_q, csum_d;
  logic [7:0]  hi_q, hi_d;
  logic [15:0] sh_seq_q, sh_seq_d, sh_snb_q, sh_snb_d;
  logic [7:0]  sh_off_q, sh_off_d, sh_na_q, sh_na_d;
  logic        first_q, first_d;
  logic        wr_bank_q, wr_bank_d;
  logic [7:0]  pl_data_q, pl_data_d;
  logic [11:0] pl_addr_q, pl_addr_d;
  logic        pl_we_q, pl_we_d;
  logic        fec_valid_q, fec_valid_d;
  logic        seq_gap_q, seq_gap_d;
  logic [15:0] rtp_seq_q, rtp_seq_d, sn_base_q, sn_base_d;
  logic [7:0]  fec_offset_q, fec_offset_d, fec_na_q, fec_na_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;

  logic        mism, good_st, any_st, in_frame, eof, start, err_fin, drop_inc;
  logic [11:0] idx, pl_off;
  logic [16:0] fold1, fold2;

  always_comb begin
    state_d = state_q; cnt_d = cnt_q; err_d = err_q; csum_d = csum_q; hi_d = hi_q;
    sh_seq_d = sh_seq_q; sh_snb_d = sh_snb_q; sh_off_d = sh_off_q; sh_na_d = sh_na_q;
    first_d = first_q; wr_bank_d = wr_bank_q;
    pl_data_d = pl_data_q; pl_addr_d = pl_addr_q; pl_we_d = 1'b0;
    fec_valid_d = 1'b0; seq_gap_d = 1'b0;
    rtp_seq_d = rtp_seq_q; sn_base_d = sn_base_q;
    fec_offset_d = fec_offset_q; fec_na_d = fec_na_q;
    drop_cnt_d = drop_cnt_q;
    mism = 1'b0; drop_inc = 1'b0; err_fin = 1'b0;
    fold1 = '0; fold2 = '0; pl_off = '0;

    // Simultaneous good+bad counts as bad.
    good_st  = rx_good_frame & ~rx_bad_frame;
    any_st   = rx_good_frame | rx_bad_frame;
    in_frame = (state_q == HDR) || (state_q == PAYLOAD);
    eof      = in_frame && !rx_data_valid;
    // A new frame may also start while still waiting for the previous status.
    start    = rx_data_valid && ((state_q == IDLE) || (state_q == WAIT_STATUS && !any_st));
    idx      = start ? 12'd0 : cnt_q;

    if (start) begin
      err_d  = 1'b0;
      csum_d = '0;
    end

    if (start || (state_q == HDR && rx_data_valid && !rx_bad_frame)) begin
      case (idx)
        12'd0:  mism = rx_data != DST_MAC[47:40];
        12'd1:  mism = rx_data != DST_MAC[39:32];
        12'd2:  mism = rx_data != DST_MAC[31:24];
        12'd3:  mism = rx_data != DST_MAC[23:16];
        12'd4:  mism = rx_data != DST_MAC[15:8];
        12'd5:  mism = rx_data != DST_MAC[7:0];
        12'd12: mism = rx_data != 8'h08;
        12'd13: mism = rx_data != 8'h00;
        12'd14: mism = rx_data != 8'h45;
        12'd23: mism = rx_data != 8'd17;          // IP protocol UDP
        12'd30: mism = rx_data != DST_IP[31:24];
        12'd31: mism = rx_data != DST_IP[23:16];
        12'd32: mism = rx_data != DST_IP[15:8];
        12'd33: mism = rx_data != DST_IP[7:0];
        12'd36: mism = rx_data != PORT_FEC[15:8];
        12'd37: mism = rx_data != PORT_FEC[7:0];
        12'd42: mism = rx_data[7:6] != 2'b10;     // RTP version 2
        12'd43: mism = rx_data[6:0] != RTP_PT;
        12'd44: sh_seq_d[15:8] = rx_data;
        12'd45: sh_seq_d[7:0]  = rx_data;
        12'd54: sh_snb_d[15:8] = rx_data;
        12'd55: sh_snb_d[7:0]  = rx_data;
        12'd58: mism = ~rx_data[7];
        12'd67: sh_off_d = rx_data;
        12'd68: sh_na_d  = rx_data;
        default: ;
      endcase
      // IPv4 header checksum: sum 16-bit words over bytes 14..33 (checksum
      // included); a correct header folds to all ones.
      if (idx >= 12'd14 && idx <= 12'd33) begin
        if (!idx[0]) hi_d = rx_data;
        else         csum_d = csum_d + {4'b0, hi_q, rx_data};
      end
      if (idx == 12'd33) begin
        fold1 = {1'b0, csum_d[15:0]} + {13'b0, csum_d[19:16]};
        fold2 = {1'b0, fold1[15:0]} + {16'b0, fold1[16]};
        if (fold2[15:0] != 16'hFFFF) mism = 1'b1;
      end
      err_d   = err_d | mism;
      cnt_d   = idx + 12'd1;
      state_d = (idx == HDR_LAST) ? PAYLOAD : HDR;
    end

    if (state_q == PAYLOAD && rx_data_valid && !rx_bad_frame) begin
      if (cnt_q < LEN) begin
        pl_off    = cnt_q - PL_OFF;
        pl_we_d   = 1'b1;
        pl_data_d = rx_data;
        pl_addr_d = {wr_bank_q, pl_off[10:0]};
      end else begin
        err_d = 1'b1;                           // overlong: never write past the buffer
      end
      if (cnt_q != 12'hFFF) cnt_d = cnt_q + 12'd1;
    end

    // MAC aborted the frame while bytes were still flowing.
    if (in_frame && rx_data_valid && rx_bad_frame) begin
      state_d  = DROP;
      drop_inc = 1'b1;
    end
    if (state_q == DROP && !rx_data_valid) state_d = IDLE;

    // Previous frame never got a status before the next one started.
    if (state_q == WAIT_STATUS && start) drop_inc = 1'b1;

    // Status may arrive on the same cycle valid drops, or any time later.
    if (eof || (state_q == WAIT_STATUS && any_st)) begin
      err_fin = err_q | (eof && cnt_q != LEN);
      if (good_st && !err_fin) begin
        state_d      = IDLE;
        wr_bank_d    = ~wr_bank_q;
        rtp_seq_d    = sh_seq_q;
        sn_base_d    = sh_snb_q;
        fec_offset_d = sh_off_q;
        fec_na_d     = sh_na_q;
        fec_valid_d  = 1'b1;
        seq_gap_d    = ~first_q & (sh_seq_q != rtp_seq_q + 16'd1);
        first_d      = 1'b0;
      end else if (any_st) begin
        state_d  = IDLE;
        drop_inc = 1'b1;
      end else begin
        state_d = WAIT_STATUS;
        err_d   = err_fin;
      end
    end

    if (drop_inc && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge rx_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE; cnt_q <= '0; err_q <= 1'b0; csum_q <= '0; hi_q <= '0;
      sh_seq_q <= '0; sh_snb_q <= '0; sh_off_q <= '0; sh_na_q <= '0;
      first_q <= 1'b1; wr_bank_q <= 1'b0;
      pl_data_q <= '0; pl_addr_q <= '0; pl_we_q <= 1'b0;
      fec_valid_q <= 1'b0; seq_gap_q <= 1'b0;
      rtp_seq_q <= '0; sn_base_q <= '0; fec_offset_q <= '0; fec_na_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q <= state_d; cnt_q <= cnt_d; err_q <= err_d; csum_q <= csum_d; hi_q <= hi_d;
      sh_seq_q <= sh_seq_d; sh_snb_q <= sh_snb_d; sh_off_q <= sh_off_d; sh_na_q <= sh_na_d;
      first_q <= first_d; wr_bank_q <= wr_bank_d;
      pl_data_q <= pl_data_d; pl_addr_q <= pl_addr_d; pl_we_q <= pl_we_d;
      fec_valid_q <= fec_valid_d; seq_gap_q <= seq_gap_d;
      rtp_seq_q <= rtp_seq_d; sn_base_q <= sn_base_d;
      fec_offset_q <= fec_offset_d; fec_na_q <= fec_na_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign pl_data    = pl_data_q;
  assign pl_addr    = pl_addr_q;
  assign pl_we      = pl_we_q;
  assign rd_bank    = ~wr_bank_q;
  assign fec_valid  = fec_valid_q;
  assign seq_gap    = seq_gap_q;
  assign rtp_seq    = rtp_seq_q;
  assign sn_base    = sn_base_q;
  assign fec_offset = fec_offset_q;
  assign fec_na     = fec_na_q;
  assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_client_my_fec_rx.sv
// Testbench for client_my_fec_rx: builds frames byte-by-byte, predicts the
// outcome from the frame contents and status, and compares DUT outputs.
module tb_client_my_fec_rx;
  localparam int FLEN = 1386;

  logic        rx_clk = 1'b0, reset_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_data_valid = 1'b0, rx_good_frame = 1'b0, rx_bad_frame = 1'b0;
  logic [7:0]  pl_data, fec_offset, fec_na;
  logic [11:0] pl_addr;
  logic        pl_we, rd_bank, fec_valid, seq_gap;
  logic [15:0] rtp_seq, sn_base, drop_cnt;

  client_my_fec_rx dut (
    .rx_clk(rx_clk), .reset_n(reset_n), .rx_data(rx_data), .rx_data_valid(rx_data_valid),
    .rx_good_frame(rx_good_frame), .rx_bad_frame(rx_bad_frame),
    .pl_data(pl_data), .pl_addr(pl_addr), .pl_we(pl_we), .rd_bank(rd_bank),
    .fec_valid(fec_valid), .rtp_seq(rtp_seq), .sn_base(sn_base),
    .fec_offset(fec_offset), .fec_na(fec_na), .seq_gap(seq_gap), .drop_cnt(drop_cnt)
  );

  always #5 rx_clk = ~rx_clk;

  int checks = 0, errors = 0;
  logic [7:0] fr [0:1399];

  // Reference model state
  logic        m_rd_bank, m_first, m_gap;
  logic [15:0] m_drop, m_seq, m_snb;
  logic [7:0]  m_off, m_na;
  int          m_fv;
  logic [19:0] exp_wq[$];

  // Output monitor
  logic [19:0] wq[$];
  int          fv_cnt = 0, bad_off = 0, nbad;
  logic        gap_seen = 1'b0;

  always @(negedge rx_clk) begin
    if (pl_we) begin
      wq.push_back({pl_addr, pl_data});
      if (pl_addr[10:0] > 11'd1315) bad_off++;
    end
    if (fec_valid) begin fv_cnt++; gap_seen = seq_gap; end
  end

  task automatic model_reset();
    m_rd_bank = 1'b1; m_first = 1'b1; m_gap = 1'b0; m_drop = 0;
    m_seq = 0; m_snb = 0; m_off = 0; m_na = 0; m_fv = 0;
  endtask

  function automatic logic csum_ok();
    int s = 0;
    for (int i = 14; i < 34; i += 2) s += {fr[i], fr[i+1]};
    while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
    return s == 32'hFFFF;
  endfunction

  function automatic logic hdr_ok();
    logic [47:0] mac = 48'h01005e7f0001;
    logic [31:0] ip  = 32'hEFFF0001;
    logic ok = 1'b1;
    for (int i = 0; i < 6; i++) if (fr[i] != mac[47-8*i -: 8]) ok = 1'b0;
    for (int i = 0; i < 4; i++) if (fr[30+i] != ip[31-8*i -: 8]) ok = 1'b0;
    if ({fr[12], fr[13]} != 16'h0800 || fr[14] != 8'h45 || fr[23] != 8'd17) ok = 1'b0;
    if ({fr[36], fr[37]} != 16'd8198) ok = 1'b0;
    if (fr[42][7:6] != 2'd2 || fr[43][6:0] != 7'd96 || !fr[58][7]) ok = 1'b0;
    return ok && csum_ok();
  endfunction

  task automatic set_csum();
    int s = 0;
    logic [15:0] c;
    fr[24] = 0; fr[25] = 0;
    for (int i = 14; i < 34; i += 2) s += {fr[i], fr[i+1]};
    while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
    c = ~s[15:0];
    fr[24] = c[15:8]; fr[25] = c[7:0];
  endtask

  task automatic build(input logic [15:0] seq, input logic [15:0] snb,
                       input logic [7:0] off, input logic [7:0] na);
    logic [47:0] mac = 48'h01005e7f0001;
    logic [31:0] ip  = 32'hEFFF0001;
    for (int i = 0; i < 1400; i++) fr[i] = 8'($urandom);
    for (int i = 0; i < 6; i++) fr[i] = mac[47-8*i -: 8];
    for (int i = 0; i < 4; i++) fr[30+i] = ip[31-8*i -: 8];
    fr[12] = 8'h08; fr[13] = 8'h00; fr[14] = 8'h45; fr[23] = 8'd17;
    fr[36] = 8'h20; fr[37] = 8'h06;
    fr[42] = {2'b10, fr[42][5:0]}; fr[43] = {fr[43][7], 7'd96};
    fr[44] = seq[15:8]; fr[45] = seq[7:0]; fr[54] = snb[15:8]; fr[55] = snb[7:0];
    fr[58] = {1'b1, fr[58][6:0]}; fr[67] = off; fr[68] = na;
    set_csum();
  endtask

  // st: 0 good, 1 bad, 2 good+bad, 3 no status. gap: idle cycles before status.
  task automatic send(input int len, input int st, input int gap);
    int lim;
    logic acc;
    logic [15:0] s;
    wq.delete(); exp_wq.delete(); fv_cnt = 0; gap_seen = 1'b0; bad_off = 0;
    lim = (len < FLEN) ? len : FLEN;
    for (int i = 70; i < lim; i++) exp_wq.push_back({~m_rd_bank, 11'(i - 70), fr[i]});
    acc = (len == FLEN) && (st == 0) && hdr_ok();
    m_fv = acc ? 1 : 0;
    m_gap = 1'b0;
    if (acc) begin
      s = {fr[44], fr[45]};
      m_gap = !m_first && (s != 16'(m_seq + 16'd1));
      m_seq = s; m_snb = {fr[54], fr[55]}; m_off = fr[67]; m_na = fr[68];
      m_rd_bank = ~m_rd_bank; m_first = 1'b0;
    end else if (m_drop != 16'hFFFF) m_drop++;
    for (int i = 0; i < len; i++) begin
      @(posedge rx_clk); #1; rx_data_valid = 1'b1; rx_data = fr[i];
    end
    @(posedge rx_clk); #1; rx_data_valid = 1'b0; rx_data = 8'h00;
    for (int g = 0; g < gap; g++) begin @(posedge rx_clk); #1; end
    if (st != 3) begin
      rx_good_frame = (st == 0 || st == 2); rx_bad_frame = (st == 1 || st == 2);
      @(posedge rx_clk); #1; rx_good_frame = 1'b0; rx_bad_frame = 1'b0;
    end
    repeat (4) @(posedge rx_clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    model_reset();
    repeat (3) @(posedge rx_clk);
    #2;
    checks++; if (rd_bank !== 1'b1) begin errors++; $display("FAIL reset.rd_bank got %0b want 1", rd_bank); end
    checks++; if ({pl_we, fec_valid, seq_gap} !== 3'b0) begin errors++; $display("FAIL reset.pulses got %b want 000", {pl_we, fec_valid, seq_gap}); end
    checks++; if ({pl_data, pl_addr} !== 20'h0) begin errors++; $display("FAIL reset.pl got %h want 0", {pl_data, pl_addr}); end
    checks++; if ({rtp_seq, sn_base, fec_offset, fec_na} !== 48'h0) begin errors++; $display("FAIL reset.fields got %h want 0", {rtp_seq, sn_base, fec_offset, fec_na}); end
    checks++; if (drop_cnt !== 16'h0) begin errors++; $display("FAIL reset.drop_cnt got %h want 0", drop_cnt); end
    reset_n = 1'b1;
    repeat (2) @(posedge rx_clk);
    #1;
  endtask

  task automatic test_valid();
    build(16'h0010, 16'h1234, 8'h07, 8'h04);
    send(FLEN, 0, 1);
    checks++; if (fv_cnt !== 1) begin errors++; $display("FAIL valid.fec_pulses got %0d want 1", fv_cnt); end
    checks++; if (rd_bank !== 1'b0) begin errors++; $display("FAIL valid.rd_bank got %0b want 0", rd_bank); end
    checks++; if (sn_base !== 16'h1234 || fec_na !== 8'h04 || rtp_seq !== 16'h0010 || fec_offset !== 8'h07) begin
      errors++; $display("FAIL valid.fields got %h %h %h %h want 0010 1234 07 04", rtp_seq, sn_base, fec_offset, fec_na); end
    checks++; if (gap_seen !== 1'b0 || drop_cnt !== 16'h0) begin errors++; $display("FAIL valid.gap_drop got %0b %0d want 0 0", gap_seen, drop_cnt); end
    nbad = 0;
    if (wq.size() != exp_wq.size()) nbad++; else foreach (wq[i]) if (wq[i] !== exp_wq[i]) nbad++;
    checks++; if (nbad != 0) begin errors++; $display("FAIL valid.writes got %0d writes (%0d bad) want %0d", wq.size(), nbad, exp_wq.size()); end
  endtask

  task automatic test_seq_gap();
    build(16'h0012, 16'h0001, 8'h01, 8'h02); send(FLEN, 0, 0);
    checks++; if (rd_bank !== 1'b1 || gap_seen !== 1'b1 || fv_cnt !== 1) begin
      errors++; $display("FAIL gap.skip got bank %0b gap %0b pulses %0d want 1 1 1", rd_bank, gap_seen, fv_cnt); end
    build(16'hFFFF, 16'h0002, 8'h01, 8'h02); send(FLEN, 0, 2);
    build(16'h0000, 16'h0003, 8'h01, 8'h02); send(FLEN, 0, 1);
    checks++; if (gap_seen !== 1'b0 || fv_cnt !== 1 || rtp_seq !== 16'h0000) begin
      errors++; $display("FAIL gap.wrap got gap %0b pulses %0d seq %h want 0 1 0000", gap_seen, fv_cnt, rtp_seq); end
  endtask

  task automatic test_rejects();
    logic b0;
    build(16'h0001, 16'h0100, 8'h01, 8'h02);
    fr[36] = 8'h20; fr[37] = 8'h04;               // port 8196
    b0 = rd_bank;
    send(FLEN, 0, 1);
    checks++; if (fv_cnt !== 0 || drop_cnt !== m_drop || rd_bank !== b0) begin
      errors++; $display("FAIL rej.port got pulses %0d drop %0d bank %0b want 0 %0d %0b", fv_cnt, drop_cnt, rd_bank, m_drop, b0); end
    build(16'h0001, 16'h0100, 8'h01, 8'h02); fr[25] = fr[25] ^ 8'h5A;
    send(FLEN, 0, 0);
    checks++; if (fv_cnt !== 0 || drop_cnt !== m_drop) begin
      errors++; $display("FAIL rej.csum got pulses %0d drop %0d want 0 %0d", fv_cnt, drop_cnt, m_drop); end
    build(16'h0001, 16'h0100, 8'h01, 8'h02);
    send(FLEN, 1, 1);
    checks++; if (fv_cnt !== 0 || drop_cnt !== m_drop || rd_bank !== b0) begin
      errors++; $display("FAIL rej.bad_status got pulses %0d drop %0d bank %0b want 0 %0d %0b", fv_cnt, drop_cnt, rd_bank, m_drop, b0); end
    send(FLEN, 2, 0);
    checks++; if (fv_cnt !== 0 || drop_cnt !== m_drop || rtp_seq !== m_seq) begin
      errors++; $display("FAIL rej.both_status got pulses %0d drop %0d seq %h want 0 %0d %h", fv_cnt, drop_cnt, rtp_seq, m_drop, m_seq); end
    send(FLEN, 3, 0);                             // no status; next frame starts
    build(16'h0002, 16'h0200, 8'h03, 8'h04);
    send(FLEN, 0, 1);
    checks++; if (fv_cnt !== 1 || drop_cnt !== m_drop || sn_base !== 16'h0200) begin
      errors++; $display("FAIL rej.no_status got pulses %0d drop %0d snb %h want 1 %0d 0200", fv_cnt, drop_cnt, sn_base, m_drop); end
  endtask

  task automatic test_length();
    build(16'h0003, 16'h0300, 8'h01, 8'h02);
    send(FLEN - 1, 0, 1);
    checks++; if (fv_cnt !== 0 || drop_cnt !== m_drop) begin
      errors++; $display("FAIL len.short got pulses %0d drop %0d want 0 %0d", fv_cnt, drop_cnt, m_drop); end
    send(FLEN + 4, 0, 1);
    checks++; if (fv_cnt !== 0 || drop_cnt !== m_drop) begin
      errors++; $display("FAIL len.long got pulses %0d drop %0d want 0 %0d", fv_cnt, drop_cnt, m_drop); end
    nbad = 0;
    if (wq.size() != exp_wq.size()) nbad++; else foreach (wq[i]) if (wq[i] !== exp_wq[i]) nbad++;
    checks++; if (nbad != 0 || bad_off != 0) begin
      errors++; $display("FAIL len.long_writes got %0d writes (%0d bad, %0d past end) want %0d", wq.size(), nbad, bad_off, exp_wq.size()); end
  endtask

  task automatic test_random();
    int kind, len, st;
    logic [15:0] seq;
    for (int n = 0; n < 8; n++) begin
      seq = $urandom_range(0, 1) ? 16'(m_seq + 16'd1) : 16'($urandom);
      build(seq, 16'($urandom), 8'($urandom), 8'($urandom));
      kind = $urandom_range(0, 3);
      len = FLEN; st = 0;
      if (kind == 1) fr[$urandom_range(0, 69)] ^= 8'($urandom_range(1, 255));
      if (kind == 2) len = FLEN + $urandom_range(0, 4) - 2;
      if (kind == 3) st = $urandom_range(0, 2);
      send(len, st, $urandom_range(0, 2));
      checks++; if (fv_cnt !== m_fv || (m_fv == 1 && gap_seen !== m_gap)) begin
        errors++; $display("FAIL rand%0d.commit got pulses %0d gap %0b want %0d %0b", n, fv_cnt, gap_seen, m_fv, m_gap); end
      checks++; if (rd_bank !== m_rd_bank || drop_cnt !== m_drop) begin
        errors++; $display("FAIL rand%0d.bank_drop got %0b %0d want %0b %0d", n, rd_bank, drop_cnt, m_rd_bank, m_drop); end
      checks++; if ({rtp_seq, sn_base, fec_offset, fec_na} !== {m_seq, m_snb, m_off, m_na}) begin
        errors++; $display("FAIL rand%0d.fields got %h want %h", n, {rtp_seq, sn_base, fec_offset, fec_na}, {m_seq, m_snb, m_off, m_na}); end
      nbad = 0;
      if (wq.size() != exp_wq.size()) nbad++; else foreach (wq[i]) if (wq[i] !== exp_wq[i]) nbad++;
      checks++; if (nbad != 0) begin
        errors++; $display("FAIL rand%0d.writes got %0d writes (%0d bad) want %0d", n, wq.size(), nbad, exp_wq.size()); end
    end
  endtask

  task automatic test_reset_mid();
    build(16'h0500, 16'h0600, 8'h01, 8'h02);
    for (int i = 0; i < 500; i++) begin
      @(posedge rx_clk); #1; rx_data_valid = 1'b1; rx_data = fr[i];
    end
    #2; reset_n = 1'b0;
    #1;
    checks++; if (rd_bank !== 1'b1 || drop_cnt !== 16'h0 || pl_we !== 1'b0 || fec_valid !== 1'b0) begin
      errors++; $display("FAIL rstmid.async got bank %0b drop %0d we %0b fv %0b want 1 0 0 0", rd_bank, drop_cnt, pl_we, fec_valid); end
    checks++; if ({rtp_seq, sn_base, fec_offset, fec_na, pl_addr, pl_data} !== 68'h0) begin
      errors++; $display("FAIL rstmid.fields got %h want 0", {rtp_seq, sn_base, fec_offset, fec_na, pl_addr, pl_data}); end
    rx_data_valid = 1'b0; rx_data = 8'h00;
    model_reset();
    repeat (2) @(posedge rx_clk);
    #1; reset_n = 1'b1;
    build(16'h0777, 16'h0888, 8'h09, 8'h0A);
    send(FLEN, 0, 1);
    checks++; if (fv_cnt !== 1 || gap_seen !== 1'b0 || rd_bank !== 1'b0 || rtp_seq !== 16'h0777) begin
      errors++; $display("FAIL rstmid.next got pulses %0d gap %0b bank %0b seq %h want 1 0 0 0777", fv_cnt, gap_seen, rd_bank, rtp_seq); end
  endtask

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog timeout");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_valid();
    test_seq_gap();
    test_rejects();
    test_length();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
